// File: rtl/running_mean_divider_if.sv
// Operand and result handshake bundle for running_mean_divider.
// The divider takes the slave side; the accumulator/result logic takes the master side.
interface running_mean_divider_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] sum;
    logic [31:0] count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mean;
    logic        div_zero;

    modport master (
        output in_valid, sum, count, out_ready,
        input  in_ready, out_valid, mean, div_zero
    );

    modport slave (
        input  in_valid, sum, count, out_ready,
        output in_ready, out_valid, mean, div_zero
    );
endinterface

// File: rtl/running_mean_divider.sv
// Iterative restoring divider: mean = signed sum / unsigned count, truncated toward zero,
// one quotient bit per cycle, valid/ready on operands and result.
module running_mean_divider (
    input  logic                       clk,
    input  logic                       rst_n,
    running_mean_divider_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_reg, state_next;
    logic        sign_reg, sign_next;
    logic [31:0] mag_reg, mag_next;
    logic [31:0] divisor_reg, divisor_next;
    logic [31:0] rem_reg, rem_next;
    logic [31:0] quot_reg, quot_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] mean_reg, mean_next;
    logic        div_zero_reg, div_zero_next;

    // The remainder never reaches the divisor after a step, so 32 bits hold it;
    // only the shifted trial value needs the extra 33rd bit.
    logic [32:0] rem_shift;
    logic [31:0] rem_sub;
    logic        step_ge;
    logic [31:0] quot_step;

    assign rem_shift = {rem_reg, mag_reg[31]};
    assign step_ge   = (rem_shift >= {1'b0, divisor_reg});
    assign rem_sub   = rem_shift[31:0] - divisor_reg;
    assign quot_step = {quot_reg[30:0], step_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sign_reg     <= 1'b0;
            mag_reg      <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            cnt_reg      <= '0;
            mean_reg     <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sign_reg     <= sign_next;
            mag_reg      <= mag_next;
            divisor_reg  <= divisor_next;
            rem_reg      <= rem_next;
            quot_reg     <= quot_next;
            cnt_reg      <= cnt_next;
            mean_reg     <= mean_next;
            div_zero_reg <= div_zero_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sign_next     = sign_reg;
        mag_next      = mag_reg;
        divisor_next  = divisor_reg;
        rem_next      = rem_reg;
        quot_next     = quot_reg;
        cnt_next      = cnt_reg;
        mean_next     = mean_reg;
        div_zero_next = div_zero_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_next    = bus.sum[31];
                    // |-2^31| wraps to 0x80000000, which is the correct unsigned magnitude
                    mag_next     = bus.sum[31] ? (~bus.sum + 32'd1) : bus.sum;
                    divisor_next = bus.count;
                    rem_next     = '0;
                    quot_next    = '0;
                    cnt_next     = 5'd31;
                    if (bus.count == 32'd0) begin
                        mean_next     = '0;
                        div_zero_next = 1'b1;
                        state_next    = DONE;
                    end else begin
                        div_zero_next = 1'b0;
                        state_next    = CALC;
                    end
                end
            end
            CALC: begin
                mag_next  = {mag_reg[30:0], 1'b0};
                rem_next  = step_ge ? rem_sub : rem_shift[31:0];
                quot_next = quot_step;
                cnt_next  = cnt_reg - 5'd1;
                if (cnt_reg == 5'd0) begin
                    mean_next  = sign_reg ? (~quot_step + 32'd1) : quot_step;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_reg == IDLE);
        bus.out_valid = (state_reg == DONE);
        bus.mean      = mean_reg;
        bus.div_zero  = div_zero_reg;
    end
endmodule
